// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared types and widths for the FIFO read-side drain scheduler.
// Stats widths are consumed only when DRAIN_STATS_EN is defined.
package fifo_drain_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP       = 3'd1,
    ST_OFFER     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } drain_state_t;

  localparam int FRAME_CNT_W = 16;
  localparam int DROP_CNT_W  = 8;

  // Width needed to hold TIMEOUT-1, never less than one bit.
  function automatic int timeout_cnt_w(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_drain_ctrl_drain_timer.sv
// Loadable down-counter with terminal-count flag, shared by the
// OFFER timeout and the inter-frame gap (never active at the same time).
module drain_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain scheduler: pops FIFO words one at a time into the UART TX.
// Optional frame/drop statistics are built when DRAIN_STATS_EN is defined.
module fifo_drain_ctrl
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [GAP_W-1:0]       gap_cfg,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   fifo_r_inc,
  output logic                   tx_valid,
  output logic [DATA_WIDTH-1:0]  tx_data,
  input  logic                   tx_busy,
  output logic                   timeout_err,
`ifdef DRAIN_STATS_EN
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [DROP_CNT_W-1:0]  drop_cnt,
`endif
  input  logic                   err_clr
);

  localparam int TO_CNT_W = timeout_cnt_w(TIMEOUT);
  localparam int TIMER_W  = max_int(TO_CNT_W, GAP_W);
  localparam logic [TIMER_W-1:0] TO_LOAD = TIMER_W'(TIMEOUT - 1);

  drain_state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  tx_valid_reg;
  logic                  timeout_err_reg;

  logic                  pop_req;
  logic                  to_hit;
  logic                  timer_load;
  logic [TIMER_W-1:0]    timer_load_val;
  logic                  timer_dec;
  logic                  timer_tc;

  drain_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .dec      (timer_dec),
    .tc       (timer_tc)
  );

  always_comb begin
    state_next     = state_reg;
    pop_req        = 1'b0;
    to_hit         = 1'b0;
    timer_load     = 1'b0;
    timer_load_val = '0;
    timer_dec      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          pop_req    = 1'b1;
          state_next = ST_POP;
        end
      end

      ST_POP: begin
        timer_load     = 1'b1;
        timer_load_val = TO_LOAD;
        state_next     = ST_OFFER;
      end

      ST_OFFER: begin
        if (tx_busy) begin
          state_next = ST_WAIT_DONE;
        end else if (timer_tc) begin
          // Transmitter never took the word: drop it and still honour the gap.
          to_hit         = 1'b1;
          timer_load     = 1'b1;
          timer_load_val = TIMER_W'(gap_cfg);
          state_next     = ST_GAP;
        end else begin
          timer_dec = 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          timer_load     = 1'b1;
          timer_load_val = TIMER_W'(gap_cfg);
          state_next     = ST_GAP;
        end
      end

      ST_GAP: begin
        if (timer_tc) begin
          state_next = ST_IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      hold_reg        <= '0;
      tx_valid_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_valid_reg <= (state_next == ST_OFFER);
      if (pop_req) begin
        hold_reg <= fifo_rd_data;
      end
      if (err_clr) begin
        timeout_err_reg <= 1'b0;
      end else if (to_hit) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

  // The pop strobe must pop in the same cycle the word is captured, and
  // must stay quiet while reset is held even though the state reads IDLE.
  assign fifo_r_inc  = pop_req & rst;
  assign tx_valid    = tx_valid_reg;
  assign tx_data     = hold_reg;
  assign timeout_err = timeout_err_reg;

`ifdef DRAIN_STATS_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;
  logic [DROP_CNT_W-1:0]  drop_cnt_reg;
  logic                   frame_done;

  assign frame_done = (state_reg == ST_WAIT_DONE) && !tx_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else if (err_clr) begin
      frame_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      if (frame_done) begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
      if (to_hit && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
